// File: rtl/clock_mode_controller.sv
// clock_mode_controller: mode sequencer for the digital alarm clock.
// Turns debounced button pulses and the alarm-match level into display/edit
// mode flags, digit selects, increment pulses and the alarm arm/ring control.
module clock_mode_controller #(
    parameter int unsigned RING_TICKS = 32'd1_500_000_000
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       BTN_MODE,
    input  logic       BTN_NEXT,
    input  logic       BTN_UP,
    input  logic       ALARM_MATCH,
    output logic       clock_set,
    output logic       alarm_set,
    output logic       alarm_ringing,
    output logic [1:0] location,
    output logic [1:0] alarm_location,
    output logic       inc_clock,
    output logic       inc_alarm,
    output logic       clock_hold,
    output logic       alarm_armed
);

    localparam int unsigned CNT_W = 31;
    localparam int unsigned LOC_W = 2;
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TICKS - 32'd1);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_CSET   = 2'd1,
        ST_ASET   = 2'd2,
        ST_RING   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               match_dly_q, match_dly_d;
    logic [CNT_W-1:0]   ring_cnt_q, ring_cnt_d;
    logic [LOC_W-1:0]   location_q, location_d;
    logic [LOC_W-1:0]   alarm_location_q, alarm_location_d;
    logic               armed_q, armed_d;
    logic               inc_clock_q, inc_clock_d;
    logic               inc_alarm_q, inc_alarm_d;
    logic               clock_set_q, clock_set_d;
    logic               alarm_set_q, alarm_set_d;
    logic               ringing_q, ringing_d;
    logic               rise;
    logic               any_btn;

    // Next-state, counter and output computation; buttons resolved MODE > NEXT > UP.
    always_comb begin
        state_d          = state_q;
        match_dly_d      = ALARM_MATCH;
        ring_cnt_d       = ring_cnt_q;
        location_d       = location_q;
        alarm_location_d = alarm_location_q;
        armed_d          = armed_q;
        inc_clock_d      = 1'b0;
        inc_alarm_d      = 1'b0;
        rise             = ALARM_MATCH & ~match_dly_q;
        any_btn          = BTN_MODE | BTN_NEXT | BTN_UP;

        case (state_q)
            ST_NORMAL: begin
                if (rise && armed_q) begin
                    state_d    = ST_RING;
                    ring_cnt_d = '0;
                end else if (BTN_MODE) begin
                    state_d    = ST_CSET;
                    location_d = '0;
                end else if (BTN_UP) begin
                    armed_d = ~armed_q;
                end
            end
            ST_CSET: begin
                if (BTN_MODE) begin
                    state_d          = ST_ASET;
                    location_d       = '0;
                    alarm_location_d = '0;
                end else if (BTN_NEXT) begin
                    location_d = location_q + LOC_W'(1);
                end else if (BTN_UP) begin
                    inc_clock_d = 1'b1;
                end
            end
            ST_ASET: begin
                if (BTN_MODE) begin
                    state_d          = ST_NORMAL;
                    armed_d          = 1'b1;
                    alarm_location_d = '0;
                end else if (BTN_NEXT) begin
                    alarm_location_d = alarm_location_q + LOC_W'(1);
                end else if (BTN_UP) begin
                    inc_alarm_d = 1'b1;
                end
            end
            ST_RING: begin
                // A button consumed here only silences the alarm.
                if (any_btn || (ring_cnt_q == RING_LAST)) begin
                    state_d    = ST_NORMAL;
                    ring_cnt_d = '0;
                end else begin
                    ring_cnt_d = ring_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase

        clock_set_d = (state_d == ST_CSET);
        alarm_set_d = (state_d == ST_ASET);
        ringing_d   = (state_d == ST_RING);
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q          <= ST_NORMAL;
            match_dly_q      <= 1'b0;
            ring_cnt_q       <= '0;
            location_q       <= '0;
            alarm_location_q <= '0;
            armed_q          <= 1'b0;
            inc_clock_q      <= 1'b0;
            inc_alarm_q      <= 1'b0;
            clock_set_q      <= 1'b0;
            alarm_set_q      <= 1'b0;
            ringing_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            match_dly_q      <= match_dly_d;
            ring_cnt_q       <= ring_cnt_d;
            location_q       <= location_d;
            alarm_location_q <= alarm_location_d;
            armed_q          <= armed_d;
            inc_clock_q      <= inc_clock_d;
            inc_alarm_q      <= inc_alarm_d;
            clock_set_q      <= clock_set_d;
            alarm_set_q      <= alarm_set_d;
            ringing_q        <= ringing_d;
        end
    end

    assign clock_set      = clock_set_q;
    assign clock_hold     = clock_set_q;
    assign alarm_set      = alarm_set_q;
    assign alarm_ringing  = ringing_q;
    assign location       = location_q;
    assign alarm_location = alarm_location_q;
    assign inc_clock      = inc_clock_q;
    assign inc_alarm      = inc_alarm_q;
    assign alarm_armed    = armed_q;

endmodule

// File: doc/clock_mode_controller.md
# clock_mode_controller

Mode sequencer for the digital alarm clock. It turns debounced button pulses and the alarm-match flag into the display and edit control signals: `clock_set`, `alarm_set`, `alarm_ringing`, `location`, and `alarm_location`. It also issues increment pulses to the time and alarm counters. It sits between the button debouncers and the time/alarm registers, and drives the mode inputs of the segment display block.

## Interface
Parameters:
- `RING_TICKS`, default 1_500_000_000: MCLK cycles the alarm rings before auto-stop (30 s at 50 MHz). It must be at least 2 and fit in 31 bits.

Ports (one clock; reset is synchronous and active-high):
- `MCLK` in 1: system clock, 50 MHz.
- `RESET` in 1: synchronous, active-high reset.
- `BTN_MODE` in 1: single-cycle pulse, already debounced.
- `BTN_NEXT` in 1: single-cycle pulse; selects the next digit.
- `BTN_UP` in 1: single-cycle pulse; increments the selected digit, or toggles arming in NORMAL.
- `ALARM_MATCH` in 1: level, high while the current time equals the alarm time.
- `clock_set` out 1: high in CSET.
- `alarm_set` out 1: high in ASET.
- `alarm_ringing` out 1: high in RING.
- `location` out 2: digit being edited in CSET; 0 in every other state.
- `alarm_location` out 2: digit being edited in ASET; 0 in every other state.
- `inc_clock` out 1: one-cycle pulse; increment clock digit `location`.
- `inc_alarm` out 1: one-cycle pulse; increment alarm digit `alarm_location`.
- `clock_hold` out 1: high in CSET; the timekeeper freezes its seconds counting.
- `alarm_armed` out 1: the alarm is enabled.

## Operation
- State encoding: NORMAL=0, CSET=1, ASET=2, RING=3. All outputs are registered.
- Button priority within a cycle is MODE > NEXT > UP. Only the highest-priority asserted button acts; the others are dropped.
- Match edge: `match_d` holds ALARM_MATCH delayed one cycle. `rise = ALARM_MATCH & ~match_d`.
- NORMAL:
  - If `rise & alarm_armed`, go to RING and clear the ring counter. This takes priority over any button in the same cycle; that button is discarded.
  - Otherwise BTN_MODE goes to CSET with `location`=0.
  - Otherwise BTN_UP toggles `alarm_armed`.
  - BTN_NEXT is ignored.
- CSET:
  - BTN_MODE goes to ASET with `alarm_location`=0.
  - BTN_NEXT sets `location` to `location`+1, wrapping 3 to 0.
  - BTN_UP pulses `inc_clock`.
  - Edges on ALARM_MATCH are ignored and never latched.
- ASET:
  - BTN_MODE goes to NORMAL and sets `alarm_armed`=1.
  - BTN_NEXT sets `alarm_location` to `alarm_location`+1, wrapping 3 to 0.
  - BTN_UP pulses `inc_alarm`.
  - ALARM_MATCH is ignored.
- RING:
  - Any button goes to NORMAL. The button is consumed and causes no other action. `alarm_armed` is unchanged.
  - Otherwise, when the 31-bit ring counter equals RING_TICKS-1, go to NORMAL.
  - Otherwise the counter increments.
- Reset mid-operation has the same effect as reset from power-up. Any pending increment pulse is cancelled.

## Timing
- Reset values: state NORMAL; every output 0; `match_d`=0; ring counter 0.
- A button sampled high on edge N produces its state and output change visible after edge N. The inc pulse is high for exactly the one cycle following the edge that sampled BTN_UP.
- Back-to-back BTN_UP pulses on consecutive cycles produce `inc_clock` high for 2 consecutive cycles.
- ALARM_MATCH is first sampled high on edge N with `match_d`=0 and `alarm_armed`=1. `alarm_ringing` is then high after edge N.
- With no button press, `alarm_ringing` stays high for exactly RING_TICKS cycles.
- ALARM_MATCH high at the moment arming occurs produces no edge and no ring until it falls and rises again.
- A button press on the same edge as the timeout ends RING in the same way (to NORMAL); no double action occurs.
- `location` and `alarm_location` are forced to 0 on leaving their set state.

## Test plan
All scenarios use RING_TICKS=8.
- Reset, then idle for 5 cycles: every output is 0 and the state is NORMAL.
- MODE, then NEXT ×5, then UP: `clock_set`=1 and `clock_hold`=1. `location` steps 1,2,3,0,1. `inc_clock` is high for 1 cycle while `location`=1.
- MODE ×2, then UP, then MODE: `alarm_set`=1 and `alarm_location`=0. `inc_alarm` pulses once. The block then returns to NORMAL with `alarm_armed`=1.
- Armed; raise ALARM_MATCH and hold it: `alarm_ringing` is high for exactly 8 cycles, then returns to NORMAL. There is no re-trigger while the match stays high.
- Armed; match rises; NEXT pulses 3 cycles later: ringing ends after the NEXT edge, `location` stays 0, and `alarm_armed` stays 1.
- BTN_MODE and a match rise arrive in the same cycle while armed: the block enters RING, not CSET.
- MODE+NEXT+UP asserted together in CSET: the block goes to ASET, with no `inc_clock` and no `location` change.
